wb_sram_arbiter: RTL

Two-port Wishbone (classic) arbiter and sequencer for the single-port payload SRAM (spram_32x256). It sits between the interconnect's SRAM target path and the SRAM macro, replacing the fixed four-cycle bridge. It grants one initiator port at a time with round-robin priority and a bounded bus lock. It drives the SRAM enable, address, write and byte-select strobes with a configurable read latency and returns ack or err per access.

---
 rtl/wb_sram_arbiter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_sram_arbiter.sv
// Two-port Wishbone classic arbiter and sequencer for the single-port payload SRAM.
// Round-robin grant with a bounded bus lock, configurable read latency, registered terminations.
module wb_sram_arbiter #(
  parameter int ADR_WIDTH  = 8,
  parameter int RD_LATENCY = 1,
  parameter int HOLD_MAX   = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [31:0]          p0_adr,
  input  logic [31:0]          p0_dat_w,
  input  logic [3:0]           p0_sel,
  input  logic                 p0_we,
  input  logic                 p0_cyc,
  input  logic                 p0_stb,
  output logic [31:0]          p0_dat_r,
  output logic                 p0_ack,
  output logic                 p0_err,
  input  logic [31:0]          p1_adr,
  input  logic [31:0]          p1_dat_w,
  input  logic [3:0]           p1_sel,
  input  logic                 p1_we,
  input  logic                 p1_cyc,
  input  logic                 p1_stb,
  output logic [31:0]          p1_dat_r,
  output logic                 p1_ack,
  output logic                 p1_err,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [ADR_WIDTH-1:0] sram_adr,
  output logic [31:0]          sram_dat_w,
  output logic [3:0]           sram_sel,
  input  logic [31:0]          sram_dat_r,
  output logic                 busy,
  output logic                 grant
);

  localparam int HCW = $clog2(HOLD_MAX + 1);
  localparam int WCW = 2;
  // Address bits between the SRAM word index and the ignored top nibble must be zero.
  localparam logic [31:0] RANGE_MASK =
    32'h0FFF_FFFF & ~((32'd1 << (ADR_WIDTH + 2)) - 32'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]  cyc_vec;
  logic [1:0]  req_vec;
  logic [1:0]  we_vec;
  logic [31:0] adr_vec   [2];
  logic [31:0] dat_w_vec [2];
  logic [3:0]  sel_vec   [2];

  assign cyc_vec      = {p1_cyc, p0_cyc};
  assign req_vec      = cyc_vec & {p1_stb, p0_stb};
  assign we_vec       = {p1_we, p0_we};
  assign adr_vec[0]   = p0_adr;
  assign adr_vec[1]   = p1_adr;
  assign dat_w_vec[0] = p0_dat_w;
  assign dat_w_vec[1] = p1_dat_w;
  assign sel_vec[0]   = p0_sel;
  assign sel_vec[1]   = p1_sel;

  logic           gnt_reg;
  logic           last_reg;
  logic           held_reg;
  logic [HCW-1:0] hold_cnt_reg, hold_cnt_next;
  logic           we_reg;
  logic [WCW-1:0] wait_cnt_reg;
  logic           busy_reg;

  logic           pick;
  logic           grant_evt;
  logic           range_err;
  logic           access_go;
  logic           resp_port;
  logic           resp_err;
  logic           resp_fire;

  // The last winner keeps priority only while it has held cyc since its grant.
  always_comb begin
    pick = req_vec[1];
    if (&req_vec) begin
      pick = (held_reg && (hold_cnt_reg < HCW'(HOLD_MAX))) ? last_reg : ~last_reg;
    end
  end

  assign range_err = |(adr_vec[pick] & RANGE_MASK);
  assign access_go = grant_evt & ~range_err;

  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (grant_evt) begin
      if ((pick == last_reg) && req_vec[~pick]) begin
        hold_cnt_next = hold_cnt_reg + HCW'(1);
      end else begin
        hold_cnt_next = HCW'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_evt  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          grant_evt  = 1'b1;
          state_next = range_err ? RESP : ACCESS;
        end
      end
      ACCESS:  state_next = we_reg ? RESP : WAIT;
      WAIT: begin
        if (wait_cnt_reg == WCW'(RD_LATENCY)) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only the range-check path enters RESP directly from IDLE, so that entry is the error case.
  assign resp_port = (state_reg == IDLE) ? pick : gnt_reg;
  assign resp_err  = (state_reg == IDLE);
  assign resp_fire = (state_next == RESP) && cyc_vec[resp_port];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= 1'b0;
      last_reg     <= 1'b1;
      held_reg     <= 1'b0;
      hold_cnt_reg <= HCW'(1);
      we_reg       <= 1'b0;
      wait_cnt_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      busy_reg     <= (state_next != IDLE);
      if (grant_evt) begin
        gnt_reg  <= pick;
        last_reg <= pick;
        held_reg <= 1'b1;
        we_reg   <= we_vec[pick];
      end else if (!cyc_vec[last_reg]) begin
        held_reg <= 1'b0;
      end
      if (state_reg == ACCESS) begin
        wait_cnt_reg <= WCW'(1);
      end else if (state_reg == WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + WCW'(1);
      end else begin
        wait_cnt_reg <= '0;
      end
    end
  end

  assign busy  = busy_reg;
  assign grant = gnt_reg;

  logic                 sram_en_reg;
  logic                 sram_we_reg;
  logic [ADR_WIDTH-1:0] sram_adr_reg;
  logic [31:0]          sram_dat_w_reg;
  logic [3:0]           sram_sel_reg;

  // SRAM strobes are loaded on the grant edge so they are valid exactly for the ACCESS cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sram_en_reg    <= 1'b0;
      sram_we_reg    <= 1'b0;
      sram_adr_reg   <= '0;
      sram_dat_w_reg <= '0;
      sram_sel_reg   <= '0;
    end else begin
      sram_en_reg <= access_go;
      sram_we_reg <= access_go && we_vec[pick];
      if (access_go) begin
        sram_adr_reg   <= adr_vec[pick][ADR_WIDTH+1:2];
        sram_dat_w_reg <= dat_w_vec[pick];
        sram_sel_reg   <= sel_vec[pick];
      end else begin
        sram_adr_reg   <= '0;
        sram_dat_w_reg <= '0;
        sram_sel_reg   <= '0;
      end
    end
  end

  assign sram_en    = sram_en_reg;
  assign sram_we    = sram_we_reg;
  assign sram_adr   = sram_adr_reg;
  assign sram_dat_w = sram_dat_w_reg;
  assign sram_sel   = sram_sel_reg;

  logic        ack_reg   [2];
  logic        err_reg   [2];
  logic [31:0] dat_r_reg [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // Read data is taken on the last WAIT edge, which is also the edge entering RESP.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          ack_reg[gi]   <= 1'b0;
          err_reg[gi]   <= 1'b0;
          dat_r_reg[gi] <= '0;
        end else begin
          ack_reg[gi]   <= resp_fire && (resp_port == 1'(gi)) && !resp_err;
          err_reg[gi]   <= resp_fire && (resp_port == 1'(gi)) && resp_err;
          dat_r_reg[gi] <= (resp_fire && (resp_port == 1'(gi)) && (state_reg == WAIT))
                           ? sram_dat_r : 32'd0;
        end
      end
    end
  endgenerate

  assign p0_ack   = ack_reg[0];
  assign p0_err   = err_reg[0];
  assign p0_dat_r = dat_r_reg[0];
  assign p1_ack   = ack_reg[1];
  assign p1_err   = err_reg[1];
  assign p1_dat_r = dat_r_reg[1];

endmodule
